// File: rtl/opll_write_sequencer.sv
// OPLL register write sequencer: buffers CPU-side writes in a small FIFO and
// replays them onto the OPLL bus with strobe width and post-write wait timing.
module opll_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_PULSE   = 4,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_a0,
  input  logic [7:0] in_data,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int WW   = $clog2(MAXW + 1);
  localparam int SW   = $clog2(WR_PULSE + 1);

  localparam logic [WW-1:0] AW_M1 = WW'(ADDR_WAIT - 1);
  localparam logic [WW-1:0] DW_M1 = WW'(DATA_WAIT - 1);
  localparam logic [SW-1:0] WP_M1 = SW'(WR_PULSE - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] str_q, str_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          wr_n_q, wr_n_d;
  logic          a0_q, a0_d;
  logic [7:0]    dat_q, dat_d;
  logic          rdy_en_q;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [WW-1:0] wait_ld;

  // Readiness only from registered state; blocked during and at reset.
  assign in_ready = rdy_en_q & (count_q < DEPTH);
  assign push     = in_valid & in_ready;
  assign o_WR_n   = wr_n_q;
  assign o_A0     = a0_q;
  assign o_D      = dat_q;
  assign o_busy   = (state_q != S_IDLE) | (count_q != '0);
  assign wait_ld  = a0_q ? DW_M1 : AW_M1;

  // Bus FSM: pop, setup, strobe, hold, then post-write wait.
  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    wait_d  = wait_q;
    a0_d    = a0_q;
    dat_d   = dat_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          {a0_d, dat_d} = mem_q[rd_ptr_q];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        str_d   = WP_M1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (str_q == '0) state_d = S_HOLD;
        else             str_d   = str_q - SW'(1);
      end
      S_HOLD: begin
        wait_d  = wait_ld;
        state_d = (wait_ld == '0) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - WW'(1);
        if (wait_q == WW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Strobe is registered so it is glitch-free and tracks state exactly.
    wr_n_d = (state_d != S_STROBE);
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a0, in_data};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      str_q    <= '0;
      wait_q   <= '0;
      wr_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      dat_q    <= '0;
      rdy_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      str_q    <= str_d;
      wait_q   <= wait_d;
      wr_n_q   <= wr_n_d;
      a0_q     <= a0_d;
      dat_q    <= dat_d;
      rdy_en_q <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: directed timing steps plus a scoreboard
// of accepted writes compared against bytes seen at each WR_n falling edge.
module tb_opll_write_sequencer;

  localparam int AW = 12;
  localparam int DW = 84;
  localparam int WP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_a0;
  logic [7:0] in_data;
  logic       o_WR_n, o_A0, o_busy;
  logic [7:0] o_D;

  logic       f_valid, f_ready, f_a0;
  logic [7:0] f_data;
  logic       f_wr_n, f_A0, f_busy;
  logic [7:0] f_D;

  always #5 clk = ~clk;

  opll_write_sequencer #(
    .FIFO_DEPTH(4), .WR_PULSE(WP), .ADDR_WAIT(AW), .DATA_WAIT(DW)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_data(in_data),
    .o_WR_n(o_WR_n), .o_A0(o_A0), .o_D(o_D), .o_busy(o_busy)
  );

  opll_write_sequencer #(
    .FIFO_DEPTH(4), .WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1)
  ) u_fast (
    .clk(clk), .rst(rst),
    .in_valid(f_valid), .in_ready(f_ready),
    .in_a0(f_a0), .in_data(f_data),
    .o_WR_n(f_wr_n), .o_A0(f_A0), .o_D(f_D), .o_busy(f_busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];
  int         cyc = 0;
  logic       prev_wr = 1'b1;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  bit         have_rise = 1'b0;
  logic       last_a0 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted push, advance, then monitor the bus.
  task automatic step();
    logic [8:0] e;
    int gap, need;
    if (in_valid && in_ready && !rst) sb.push_back({in_a0, in_data});
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      prev_wr   = 1'b1;
      have_rise = 1'b0;
    end else begin
      if (prev_wr && !o_WR_n) begin
        chk("emit_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("emit_a0_d", {o_A0, o_D}, e);
        end
        if (have_rise) begin
          gap  = cyc - rise_cyc;
          need = (last_a0 ? DW : AW) + 2;
          chk("gap_min", (gap >= need) ? need : gap, need);
        end
        fall_cyc = cyc;
        last_a0  = o_A0;
      end
      if (!prev_wr && o_WR_n) begin
        chk("low_width", cyc - fall_cyc, WP);
        rise_cyc  = cyc;
        have_rise = 1'b1;
      end
      prev_wr = o_WR_n;
    end
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 3000 && (o_busy || sb.size() != 0); n++) step();
    chk({tag, "_idle"}, o_busy, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    logic       fw [24];
    logic       fa [24];
    logic [7:0] fd [24];
    int f1, r1, f2, i;
    logic acc;

    rst = 1'b1;
    in_valid = 1'b1; in_a0 = 1'b1; in_data = 8'hFF;
    f_valid = 1'b0; f_a0 = 1'b0; f_data = 8'h00;
    repeat (3) step();
    chk("rst_wr_n", o_WR_n, 1);
    chk("rst_a0", o_A0, 0);
    chk("rst_d", o_D, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("ready_after_rst", in_ready, 1);
    chk("f_ready_after_rst", f_ready, 1);

    // Minimal timing: 1-cycle strobe, no wait, 3-cycle rise-to-fall gap.
    f_valid = 1'b1; f_a0 = 1'b0; f_data = 8'h5A;
    step();
    f_a0 = 1'b1; f_data = 8'h6B;
    step();
    f_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      fw[k] = f_wr_n; fa[k] = f_A0; fd[k] = f_D;
      step();
    end
    f1 = -1; r1 = -1; f2 = -1;
    for (int k = 1; k < 24; k++) begin
      if (fw[k-1] && !fw[k]) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
      if (!fw[k-1] && fw[k] && r1 < 0) r1 = k;
    end
    chk("fast_low_width", r1 - f1, 1);
    chk("fast_gap", f2 - r1, 3);
    chk("fast_d1", fd[(f1 < 0) ? 0 : f1], 8'h5A);
    chk("fast_d2", {fa[(f2 < 0) ? 0 : f2], fd[(f2 < 0) ? 0 : f2]},
        {1'b1, 8'h6B});
    chk("fast_idle", f_busy, 0);

    // Single address write.
    in_valid = 1'b1; in_a0 = 1'b0; in_data = 8'h10;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk("s_wr_n", o_WR_n, (k >= 3 && k <= 6) ? 0 : 1);
      chk("s_busy", o_busy, (k < 19) ? 1 : 0);
      if (k >= 2) chk("s_a0_d", {o_A0, o_D}, {1'b0, 8'h10});
      step();
    end

    // Address then data write, back to back.
    in_valid = 1'b1; in_a0 = 1'b0; in_data = 8'h10;
    step();
    in_a0 = 1'b1; in_data = 8'h25;
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 110; k++) begin
      chk("ad_wr_n", o_WR_n,
          ((k >= 3 && k <= 6) || (k >= 21 && k <= 24)) ? 0 : 1);
      chk("ad_busy", o_busy, (k < 109) ? 1 : 0);
      if (k == 6)  chk("ad_first", {o_A0, o_D}, {1'b0, 8'h10});
      if (k >= 21 && k <= 24) chk("ad_second", {o_A0, o_D}, {1'b1, 8'h25});
      step();
    end

    // Fill: first entry pops one cycle after its push, so four more
    // pushes fit and the sixth offer sees a full FIFO.
    i = 0;
    in_valid = 1'b1; in_a0 = 1'b0; in_data = 8'hA0;
    for (int k = 0; k <= 5; k++) begin
      chk("fill_ready", in_ready, (k < 5) ? 1 : 0);
      acc = in_ready;
      step();
      if (acc) begin
        i++;
        in_a0 = i[0];
        in_data = 8'(8'hA0 + i);
      end
    end
    for (int n = 0; n < 500 && !in_ready; n++) step();
    chk("fill_ready_return", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain("fill");

    // Reset in the second strobe cycle discards the queue.
    in_valid = 1'b1; in_a0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h31 + k);
      step();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 100 && o_WR_n; n++) step();
    chk("mr_strobe_seen", o_WR_n, 0);
    step();
    chk("mr_strobe2", o_WR_n, 0);
    rst = 1'b1;
    step();
    chk("mr_wr_n", o_WR_n, 1);
    chk("mr_busy", o_busy, 0);
    chk("mr_ready", in_ready, 0);
    sb.delete();
    rst = 1'b0;
    step();
    chk("mr_ready_after", in_ready, 1);
    repeat (300) step();
    chk("mr_quiet", o_busy, 0);

    // Random traffic through the scoreboard.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_a0    = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      step();
    end
    in_valid = 1'b0;
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
